// File: rtl/retire_stage_pkg.sv
// Shared types and sizing for the retire stage.
//   WIDTH                   : retire slots per cycle (slot 0 is oldest)
//   ARCH_REGS / ARCH_W      : architectural register count / index width
//   SYS_PHYS_REG_ADDR_WIDTH : physical register tag width (PR_W)
//   retire_state_e          : RUN / RECOVER / HALT
//   retire_slot_t           : one ROB head slot as seen by the retire logic
package retire_stage_pkg;

  localparam int SYS_PHYS_REG_ADDR_WIDTH = 6;
  localparam int WIDTH     = 3;
  localparam int ARCH_REGS = 32;
  localparam int ARCH_W    = $clog2(ARCH_REGS);
  localparam int PR_W      = SYS_PHYS_REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    HALT    = 2'd2
  } retire_state_e;

  typedef struct packed {
    logic              valid;
    logic              complete;
    logic              has_dest;
    logic [ARCH_W-1:0] arch_reg;
    logic [PR_W-1:0]   new_pr;
    logic              mispredict;
    logic              halt;
  } retire_slot_t;

endpackage

// File: rtl/retire_stage_if.sv
// ROB-head / Freelist / fetch-recovery bundle around the retire stage.
//   rob_head_*          : ROB head slots, driven by the ROB side
//   rob_retire_mask     : slots popped this cycle (combinational)
//   fl_retire_en_mask   : Freelist retire enables (registered)
//   fl_retired_pr_list  : freed physical registers (registered)
//   fch_rec_enable      : one-cycle branch recovery pulse (registered)
// master = ROB/Freelist side, slave = retire stage.
interface retire_stage_if;
  import retire_stage_pkg::*;

  logic [WIDTH-1:0]             rob_head_valid;
  logic [WIDTH-1:0]             rob_head_complete;
  logic [WIDTH-1:0]             rob_head_has_dest;
  logic [WIDTH-1:0][ARCH_W-1:0] rob_head_arch_reg;
  logic [WIDTH-1:0][PR_W-1:0]   rob_head_new_pr;
  logic [WIDTH-1:0]             rob_head_mispredict;
  logic [WIDTH-1:0]             rob_head_halt;
  logic [WIDTH-1:0]             rob_retire_mask;
  logic [WIDTH-1:0]             fl_retire_en_mask;
  logic [WIDTH-1:0][PR_W-1:0]   fl_retired_pr_list;
  logic                         fch_rec_enable;

  modport master (
    output rob_head_valid, rob_head_complete, rob_head_has_dest,
           rob_head_arch_reg, rob_head_new_pr, rob_head_mispredict, rob_head_halt,
    input  rob_retire_mask, fl_retire_en_mask, fl_retired_pr_list, fch_rec_enable
  );

  modport slave (
    input  rob_head_valid, rob_head_complete, rob_head_has_dest,
           rob_head_arch_reg, rob_head_new_pr, rob_head_mispredict, rob_head_halt,
    output rob_retire_mask, fl_retire_en_mask, fl_retired_pr_list, fch_rec_enable
  );

endinterface

// File: rtl/retire_amt.sv
// Architectural map table with WIDTH ordered write ports.
//   clk, rst : clock, synchronous active-low reset (AMT[i] = i)
//   wr_en    : per-port write enable (port k = retire slot k)
//   wr_idx   : per-port arch register index (also the read index)
//   wr_data  : per-port new physical register
//   rd_data  : per-port superseded physical register, bypassed from older
//              ports in the same group
//   amt_map  : registered AMT contents
module retire_amt
  import retire_stage_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               wr_en,
  input  logic [WIDTH-1:0][ARCH_W-1:0]   wr_idx,
  input  logic [WIDTH-1:0][PR_W-1:0]     wr_data,
  output logic [WIDTH-1:0][PR_W-1:0]     rd_data,
  output logic [ARCH_REGS-1:0][PR_W-1:0] amt_map
);

  logic [ARCH_REGS-1:0][PR_W-1:0] amt_q;

  // Ports are applied oldest first so the youngest writer of an index wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        amt_q[i] <= PR_W'(i);
      end
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (wr_en[k]) begin
          amt_q[wr_idx[k]] <= wr_data[k];
        end
      end
    end
  end

  // The newest older writer of the same index supersedes the stored value,
  // so scanning j upward leaves the youngest match in place.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < WIDTH; k++) begin
      rd_data[k] = amt_q[wr_idx[k]];
      for (int j = 0; j < k; j++) begin
        if (wr_en[j] && (wr_idx[j] == wr_idx[k])) begin
          rd_data[k] = wr_data[j];
        end
      end
    end
  end

  assign amt_map = amt_q;

endmodule

// File: rtl/retire_stage.sv
// In-order WIDTH-wide commit stage between the ROB head and the Freelist.
//   clk, rst : clock, synchronous active-low reset
//   bus      : ROB head inputs, retire mask, Freelist frees, recovery pulse
//   amt_map  : registered architectural map table
//   halted   : set once a halt instruction retires, held until reset
//
// state   | meaning
// --------+-------------------------------------------------------
// RUN     | normal retirement of the oldest complete prefix
// RECOVER | one cycle after a mispredict retires; nothing retires
// HALT    | a halt retired; nothing retires until reset
module retire_stage
  import retire_stage_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  retire_stage_if.slave                  bus,
  output logic [ARCH_REGS-1:0][PR_W-1:0] amt_map,
  output logic                           halted
);

  retire_state_e                state_q, state_d;
  retire_slot_t [WIDTH-1:0]     slot;
  logic [WIDTH-1:0]             retire_mask;
  logic [WIDTH-1:0]             wr_en;
  logic [WIDTH-1:0][ARCH_W-1:0] wr_idx;
  logic [WIDTH-1:0][PR_W-1:0]   wr_data;
  logic [WIDTH-1:0][PR_W-1:0]   freed_pr;
  logic                         chain_ok;
  logic                         hit_mis;
  logic                         hit_halt;
  logic [WIDTH-1:0]             fl_en_q;
  logic [WIDTH-1:0][PR_W-1:0]   fl_pr_q;
  logic                         rec_q;
  logic                         halted_q;

  always_comb begin
    slot = '0;
    for (int k = 0; k < WIDTH; k++) begin
      slot[k].valid      = bus.rob_head_valid[k];
      slot[k].complete   = bus.rob_head_complete[k];
      slot[k].has_dest   = bus.rob_head_has_dest[k];
      slot[k].arch_reg   = bus.rob_head_arch_reg[k];
      slot[k].new_pr     = bus.rob_head_new_pr[k];
      slot[k].mispredict = bus.rob_head_mispredict[k];
      slot[k].halt       = bus.rob_head_halt[k];
    end
  end

  // Retire selection and next state. chain_ok drops at the first slot that
  // cannot retire or that ends the group (halt takes priority over mispredict).
  always_comb begin
    state_d     = state_q;
    retire_mask = '0;
    hit_mis     = 1'b0;
    hit_halt    = 1'b0;
    chain_ok    = rst && (state_q == RUN);
    for (int k = 0; k < WIDTH; k++) begin
      if (chain_ok && slot[k].valid && slot[k].complete) begin
        retire_mask[k] = 1'b1;
        if (slot[k].halt) begin
          hit_halt = 1'b1;
          chain_ok = 1'b0;
        end else if (slot[k].mispredict) begin
          hit_mis  = 1'b1;
          chain_ok = 1'b0;
        end
      end else begin
        chain_ok = 1'b0;
      end
    end
    case (state_q)
      RUN: begin
        if (hit_halt) begin
          state_d = HALT;
        end else if (hit_mis) begin
          state_d = RECOVER;
        end
      end
      RECOVER: state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    wr_en   = '0;
    wr_idx  = '0;
    wr_data = '0;
    for (int k = 0; k < WIDTH; k++) begin
      // Arch reg 0 is hardwired, so it neither frees nor remaps.
      wr_en[k]   = retire_mask[k] && slot[k].has_dest && (slot[k].arch_reg != '0);
      wr_idx[k]  = slot[k].arch_reg;
      wr_data[k] = slot[k].new_pr;
    end
  end

  retire_amt u_amt (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_data (freed_pr),
    .amt_map (amt_map)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      fl_en_q  <= '0;
      fl_pr_q  <= '0;
      rec_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fl_en_q <= wr_en;
      for (int k = 0; k < WIDTH; k++) begin
        fl_pr_q[k] <= wr_en[k] ? freed_pr[k] : '0;
      end
      rec_q    <= (state_d == RECOVER);
      halted_q <= (state_d == HALT);
    end
  end

  assign bus.rob_retire_mask    = retire_mask;
  assign bus.fl_retire_en_mask  = fl_en_q;
  assign bus.fl_retired_pr_list = fl_pr_q;
  assign bus.fch_rec_enable     = rec_q;
  assign halted                 = halted_q;

endmodule
